gpu_cmd_queue: RTL
==================

GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 The module SHALL have parameter FB_WIDTH, default 400, meaning framebuffer width; X field width XW = $clog2(FB_WIDTH)+2.
REQ-002 The module SHALL have parameter FB_HEIGHT, default 240, meaning framebuffer height; Y field width YW = $clog2(FB_HEIGHT)+2.
REQ-003 The module SHALL have parameter DEPTH, default 8, a power of 2 >= 2, meaning command FIFO entries.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset: clk (in, 1, sole clock) and reset_n (in, 1, async active-low reset).
REQ-005 The command input ports SHALL be cmd_valid in 1; cmd_ready out 1; cmd_op in 1 (0=draw, 1=clear); cmd_address in 32; cmd_address_x in 16; cmd_address_y in 16; cmd_image_width in 16; cmd_width in XW; cmd_height in YW; cmd_x in XW; cmd_y in YW; cmd_color in 16.
REQ-006 The queue control ports SHALL be flush in 1 (drop queued, un-issued commands); queue_level out $clog2(DEPTH)+1 (entries held); queue_idle out 1 (nothing queued or in flight).
REQ-007 The GPU-side ports SHALL be ctrl_address out 32; ctrl_address_x out 16; ctrl_address_y out 16; ctrl_image_width out 16; ctrl_width out XW; ctrl_height out YW; ctrl_x out XW; ctrl_y out YW; ctrl_clear_color out 16; ctrl_draw out 1; ctrl_clear out 1; gpu_busy in 1.
REQ-008 The stats port SHALL be stat_done out 32 (count of completed commands).

Function
REQ-009 A command SHALL be pushed on a rising clk edge where cmd_valid && cmd_ready; all cmd_* fields are stored as one entry.
REQ-010 cmd_ready SHALL equal (queue_level != DEPTH); a push while full SHALL be impossible, and cmd_valid while full SHALL not alter state.
REQ-011 The FSM SHALL have the states IDLE, LOAD, PULSE and WAIT.
REQ-012 IDLE SHALL pop the head into the ctrl_* field registers and go to LOAD on the next edge if the FIFO is non-empty && !gpu_busy; otherwise it SHALL stay in IDLE.
REQ-013 LOAD SHALL last exactly 1 cycle, with fields stable and strobes low, then go to PULSE.
REQ-014 PULSE SHALL last exactly 1 cycle: ctrl_draw=1 if op=0, else ctrl_clear=1; it SHALL then go to WAIT.
REQ-015 WAIT SHALL hold while gpu_busy=1 and go to IDLE on the first edge with gpu_busy=0; stat_done SHALL increment on that edge.
REQ-016 ctrl_draw and ctrl_clear SHALL be registered, high only in PULSE and never both high.
REQ-017 Every ctrl_* field SHALL stay constant from LOAD through WAIT.
REQ-018 For a clear command, ctrl_clear_color SHALL take cmd_color; the draw fields SHALL be loaded as well but their values are don't-care.
REQ-019 For a draw command, ctrl_clear_color SHALL retain its previous value.
REQ-020 Latency: for a push at edge 0 into an empty queue in IDLE, the strobe SHALL be high between edges 2 and 3.
REQ-021 Back-to-back commands: the next LOAD SHALL begin no earlier than 1 cycle after WAIT exits.
REQ-022 A simultaneous push and pop SHALL leave queue_level unchanged; a push to an empty FIFO is not bypassed and pops no earlier than the next edge.
REQ-023 flush SHALL empty the FIFO on that edge, taking priority over a same-cycle push (push dropped) and pop (no pop); an in-flight command SHALL complete normally.
REQ-024 queue_idle SHALL equal (FSM==IDLE && queue_level==0 && !gpu_busy).
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 stat_done SHALL wrap from 2^32-1 to 0.

Reset
REQ-027 On reset_n=0 the FSM SHALL be IDLE and the FIFO empty, with queue_level=0, cmd_ready=1, ctrl_draw=0, ctrl_clear=0, all ctrl_* fields=0 and stat_done=0; queue_idle then follows REQ-024 (1 while gpu_busy=0).
REQ-028 Reset asserted mid-command SHALL abort immediately and deassert the strobes; the queued entries SHALL be discarded.

Configuration
REQ-029 The macro GPU_CMD_QUEUE_STATS_EN SHALL control statistics: when defined, stat_done counts per REQ-015 and REQ-026; when undefined, stat_done SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-030 The bench SHALL cover: push 1 draw (x=10, y=20, w=16, h=16) at edge 0 with gpu_busy=0 -> fields valid from edge 1, ctrl_draw high only between edges 2 and 3.
REQ-031 The bench SHALL cover: push a clear with color 0xF801, gpu_busy held high for 5 cycles after the pulse -> ctrl_clear high for 1 cycle, ctrl_clear_color=0xF801 through WAIT, queue_idle=0 until busy falls.
REQ-032 The bench SHALL cover: push 9 commands back-to-back with DEPTH=8 and gpu_busy=1 -> cmd_ready=0 once queue_level=8; all pushed commands issue in order once busy drops.
REQ-033 The bench SHALL cover: queue 3 entries, assert flush in the same cycle as cmd_valid -> queue_level=0, pushed entry dropped, in-flight command completes, stat_done +1.
REQ-034 The bench SHALL cover: assert reset_n=0 during WAIT -> strobes and fields 0, queue_level=0 immediately, without waiting for a clk edge.
REQ-035 The bench SHALL cover: run 4 commands with the macro defined -> stat_done=4; same test with the macro undefined -> stat_done=0 throughout.

Source files
------------

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: buffers drawing/clearing commands in a DEPTH-entry FIFO and
// hands them one at a time to a GPU through registered ctrl_* fields and a
// one-cycle ctrl_draw / ctrl_clear strobe, then waits for gpu_busy to drop.
//
// Ports:
//   clk, reset_n          sole clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command push handshake; cmd_* fields form one entry
//   flush                 drops queued (not yet issued) commands
//   queue_level           number of entries held in the FIFO
//   queue_idle            nothing queued, nothing in flight, GPU not busy
//   ctrl_*                command fields presented to the GPU
//   ctrl_draw/ctrl_clear  one-cycle issue strobes
//   gpu_busy              GPU is processing the issued command
//   stat_done             completed-command counter
//
// Build option: define GPU_CMD_QUEUE_STATS_EN to build the stat_done counter;
// without it stat_done is tied to zero.
module gpu_cmd_queue #(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240,
  parameter int unsigned DEPTH     = 8,
  localparam int unsigned XW = $clog2(FB_WIDTH) + 2,
  localparam int unsigned YW = $clog2(FB_HEIGHT) + 2,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [31:0]   cmd_address,
  input  logic [15:0]   cmd_address_x,
  input  logic [15:0]   cmd_address_y,
  input  logic [15:0]   cmd_image_width,
  input  logic [XW-1:0] cmd_width,
  input  logic [YW-1:0] cmd_height,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [15:0]   cmd_color,
  input  logic          flush,
  output logic [LW-1:0] queue_level,
  output logic          queue_idle,
  output logic [31:0]   ctrl_address,
  output logic [15:0]   ctrl_address_x,
  output logic [15:0]   ctrl_address_y,
  output logic [15:0]   ctrl_image_width,
  output logic [XW-1:0] ctrl_width,
  output logic [YW-1:0] ctrl_height,
  output logic [XW-1:0] ctrl_x,
  output logic [YW-1:0] ctrl_y,
  output logic [15:0]   ctrl_clear_color,
  output logic          ctrl_draw,
  output logic          ctrl_clear,
  input  logic          gpu_busy,
  output logic [31:0]   stat_done
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic          op;
    logic [31:0]   address;
    logic [15:0]   address_x;
    logic [15:0]   address_y;
    logic [15:0]   image_width;
    logic [XW-1:0] width;
    logic [YW-1:0] height;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   color;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, PULSE, WAIT} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  state_t          state;
  logic            cur_op;
  logic            push;
  logic            pop;

  assign cmd_ready   = (level != LW'(DEPTH));
  assign queue_level = level;
  assign queue_idle  = (state == IDLE) && (level == '0) && !gpu_busy;
  assign head        = mem[rd_ptr];

  // flush wins over both a same-cycle push and a same-cycle pop
  assign push = cmd_valid && cmd_ready && !flush;
  assign pop  = (state == IDLE) && (level != '0) && !gpu_busy && !flush;

  // Storage carries no reset: a reset empties the queue through level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, address: cmd_address, address_x: cmd_address_x,
                       address_y: cmd_address_y, image_width: cmd_image_width,
                       width: cmd_width, height: cmd_height, x: cmd_x, y: cmd_y,
                       color: cmd_color};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      state            <= IDLE;
      cur_op           <= 1'b0;
      ctrl_address     <= '0;
      ctrl_address_x   <= '0;
      ctrl_address_y   <= '0;
      ctrl_image_width <= '0;
      ctrl_width       <= '0;
      ctrl_height      <= '0;
      ctrl_x           <= '0;
      ctrl_y           <= '0;
      ctrl_clear_color <= '0;
      ctrl_draw        <= 1'b0;
      ctrl_clear       <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end

      case (state)
        IDLE: begin
          if (pop) begin
            cur_op           <= head.op;
            ctrl_address     <= head.address;
            ctrl_address_x   <= head.address_x;
            ctrl_address_y   <= head.address_y;
            ctrl_image_width <= head.image_width;
            ctrl_width       <= head.width;
            ctrl_height      <= head.height;
            ctrl_x           <= head.x;
            ctrl_y           <= head.y;
            // a draw keeps the last clear colour
            if (head.op) ctrl_clear_color <= head.color;
            state <= LOAD;
          end
        end
        LOAD: begin
          ctrl_draw  <= !cur_op;
          ctrl_clear <= cur_op;
          state      <= PULSE;
        end
        PULSE: begin
          ctrl_draw  <= 1'b0;
          ctrl_clear <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (!gpu_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPU_CMD_QUEUE_STATS_EN
  logic [31:0] done_cnt;

  // counts on the edge that leaves WAIT; wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt <= '0;
    end else if ((state == WAIT) && !gpu_busy) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end

  assign stat_done = done_cnt;
`else
  assign stat_done = '0;
`endif

endmodule
